v_value_slice_engine: RTL and testbench



---
 rtl/div_pkg.sv | 32 +++
 rtl/dual_port_v_ram_div.sv | 43 ++++
 rtl/v_value_slice_engine.sv | 231 +++++++++++++++++++++++
 tb/tb_v_value_slice_engine.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the V-value slice engine: quotient-digit encoding,
// controller states and the quotient-digit selection function.
package div_pkg;

    localparam logic [1:0] Q_POS  = 2'b10;
    localparam logic [1:0] Q_NEG  = 2'b01;
    localparam logic [1:0] Q_ZERO = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_UPPER,
        ST_BORROW,
        ST_QSEL,
        ST_FIX
    } state_e;

    // The top four bits of the signed upper V estimate decide the digit.
    // 0000 and 1111 straddle zero, so they select 0.
    function automatic logic [1:0] q_select(input logic [3:0] top4);
        logic [1:0] q;
        if (top4 == 4'b0000 || top4 == 4'b1111) begin
            q = Q_ZERO;
        end else if (top4[3] == 1'b0) begin
            q = Q_POS;
        end else begin
            q = Q_NEG;
        end
        return q;
    endfunction

endpackage

// File: rtl/dual_port_v_ram_div.sv
// V-slice storage: one write port and one synchronous read port whose
// address is shared between the borrow pass and the external reader.
module dual_port_v_ram_div
    import div_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int NUM_SLICES = 8,
    parameter int AW         = $clog2(NUM_SLICES)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [2*DIGITS-1:0]   wr_data,
    input  logic                  borrow_rd,
    input  logic [AW-1:0]         borrow_addr,
    input  logic                  ext_rd_en,
    input  logic [AW-1:0]         ext_rd_addr,
    output logic [2*DIGITS-1:0]   rd_data
);

    logic [2*DIGITS-1:0] mem_q [NUM_SLICES];
    logic [2*DIGITS-1:0] rd_data_q;
    logic                rd_en;
    logic [AW-1:0]       rd_addr;

    // The borrow pass owns the read port whenever it is active.
    always_comb begin
        rd_en   = borrow_rd | ext_rd_en;
        rd_addr = borrow_rd ? borrow_addr : ext_rd_addr;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/v_value_slice_engine.sv
// Per-iteration V-value engine: sliced carry-save addition into a V RAM,
// upper-field formation, borrow pass, quotient-digit selection and replay.
module v_value_slice_engine
    import div_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int NUM_SLICES = 8,
    parameter int UPPER_BITS = 6,
    parameter int Q_DEPTH    = 16,
    parameter int SLICE_AW   = $clog2(NUM_SLICES),
    parameter int Q_AW       = $clog2(Q_DEPTH)
) (
    input  logic                  clk,
    input  logic                  clear_n,
    input  logic                  start,
    input  logic                  fixing,
    input  logic [Q_AW-1:0]       fix_idx,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIGITS-1:0]     q_plus_vec,
    input  logic [DIGITS-1:0]     q_minus_vec,
    input  logic [DIGITS-1:0]     residue_plus,
    input  logic [DIGITS-1:0]     residue_minus,
    input  logic [UPPER_BITS-1:0] res_upper_plus,
    input  logic [UPPER_BITS-1:0] res_upper_minus,
    input  logic [1:0]            x_value_reg,
    input  logic                  v_rd_en,
    input  logic [SLICE_AW-1:0]   v_rd_addr,
    output logic [DIGITS-1:0]     v_plus_rd,
    output logic [DIGITS-1:0]     v_minus_rd,
    output logic [UPPER_BITS-1:0] v_upper_plus,
    output logic [UPPER_BITS-1:0] v_upper_minus,
    output logic                  busy,
    output logic                  q_valid,
    output logic [1:0]            q_value,
    output logic [Q_AW-1:0]       iter_cnt
);

    localparam logic [SLICE_AW-1:0] SLICE_LAST  = SLICE_AW'(NUM_SLICES - 1);
    localparam logic [SLICE_AW:0]   BORROW_LAST = (SLICE_AW + 1)'(NUM_SLICES);
    localparam logic [Q_AW-1:0]     Q_LAST      = Q_AW'(Q_DEPTH - 1);

    state_e                state_q, state_d;
    logic [SLICE_AW-1:0]   slice_q, slice_d;
    logic                  cin_p_q, cin_p_d;
    logic                  cin_m_q, cin_m_d;
    logic [SLICE_AW:0]     bcnt_q, bcnt_d;
    logic                  borrow_q, borrow_d;
    logic [UPPER_BITS-1:0] v_upper_plus_q, v_upper_plus_d;
    logic [UPPER_BITS-1:0] v_upper_minus_q, v_upper_minus_d;
    logic [1:0]            q_value_q, q_value_d;
    logic                  q_valid_q, q_valid_d;
    logic [Q_AW-1:0]       iter_cnt_q, iter_cnt_d;
    logic [Q_AW-1:0]       fix_idx_q, fix_idx_d;
    logic                  ext_rd_valid_q, ext_rd_valid_d;
    logic [1:0]            q_hist_q [Q_DEPTH];

    logic [DIGITS:0]       sum_p, sum_m;
    logic [UPPER_BITS-1:0] u_val;
    logic                  ram_wr_en;
    logic                  borrow_rd;
    logic                  ext_rd_en;
    logic                  hist_wr_en;
    logic [2*DIGITS-1:0]   rd_data;
    logic [DIGITS-1:0]     rd_vp, rd_vm;
    logic                  ext_out_en;

    assign rd_vp = rd_data[2*DIGITS-1:DIGITS];
    assign rd_vm = rd_data[DIGITS-1:0];

    always_comb begin
        sum_p = {1'b0, q_plus_vec} + {1'b0, residue_plus} + {{DIGITS{1'b0}}, cin_p_q};
        sum_m = {1'b0, q_minus_vec} + {1'b0, residue_minus} + {{DIGITS{1'b0}}, cin_m_q};
        u_val = v_upper_plus_q - v_upper_minus_q - {{(UPPER_BITS-1){1'b0}}, borrow_q};
    end

    // Next-state and datapath control; every register holds unless its state acts.
    always_comb begin
        state_d         = state_q;
        slice_d         = slice_q;
        cin_p_d         = cin_p_q;
        cin_m_d         = cin_m_q;
        bcnt_d          = bcnt_q;
        borrow_d        = borrow_q;
        v_upper_plus_d  = v_upper_plus_q;
        v_upper_minus_d = v_upper_minus_q;
        q_value_d       = q_value_q;
        q_valid_d       = 1'b0;
        iter_cnt_d      = iter_cnt_q;
        fix_idx_d       = fix_idx_q;
        ram_wr_en       = 1'b0;
        borrow_rd       = 1'b0;
        hist_wr_en      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (fixing) begin
                        fix_idx_d = fix_idx;
                        state_d   = ST_FIX;
                    end else begin
                        slice_d = '0;
                        cin_p_d = 1'b0;
                        cin_m_d = 1'b0;
                        state_d = ST_ADD;
                    end
                end
            end
            ST_ADD: begin
                if (in_valid) begin
                    ram_wr_en = 1'b1;
                    cin_p_d   = sum_p[DIGITS];
                    cin_m_d   = sum_m[DIGITS];
                    if (slice_q == SLICE_LAST) begin
                        state_d = ST_UPPER;
                    end else begin
                        slice_d = slice_q + 1'b1;
                    end
                end
            end
            ST_UPPER: begin
                v_upper_plus_d  = res_upper_plus + UPPER_BITS'(cin_p_q)
                                + UPPER_BITS'(x_value_reg[1]);
                v_upper_minus_d = res_upper_minus + UPPER_BITS'(cin_m_q)
                                + UPPER_BITS'(x_value_reg[0]);
                borrow_d        = 1'b0;
                bcnt_d          = '0;
                state_d         = ST_BORROW;
            end
            ST_BORROW: begin
                // Read of slice k is issued at count k and consumed at count k+1.
                borrow_rd = (bcnt_q != BORROW_LAST);
                if (bcnt_q != '0) begin
                    borrow_d = ({1'b0, rd_vp} < ({1'b0, rd_vm} + {{DIGITS{1'b0}}, borrow_q}));
                end
                if (bcnt_q == BORROW_LAST) begin
                    state_d = ST_QSEL;
                end else begin
                    bcnt_d = bcnt_q + 1'b1;
                end
            end
            ST_QSEL: begin
                q_value_d  = q_select(4'(u_val >> (UPPER_BITS - 4)));
                q_valid_d  = 1'b1;
                hist_wr_en = 1'b1;
                iter_cnt_d = (iter_cnt_q == Q_LAST) ? '0 : iter_cnt_q + 1'b1;
                state_d    = ST_IDLE;
            end
            ST_FIX: begin
                q_value_d = q_hist_q[fix_idx_q];
                q_valid_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ext_rd_en      = v_rd_en && (state_q == ST_IDLE);
        ext_rd_valid_d = ext_rd_en;
    end

    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q         <= ST_IDLE;
            slice_q         <= '0;
            cin_p_q         <= 1'b0;
            cin_m_q         <= 1'b0;
            bcnt_q          <= '0;
            borrow_q        <= 1'b0;
            v_upper_plus_q  <= '0;
            v_upper_minus_q <= '0;
            q_value_q       <= Q_ZERO;
            q_valid_q       <= 1'b0;
            iter_cnt_q      <= '0;
            fix_idx_q       <= '0;
            ext_rd_valid_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            slice_q         <= slice_d;
            cin_p_q         <= cin_p_d;
            cin_m_q         <= cin_m_d;
            bcnt_q          <= bcnt_d;
            borrow_q        <= borrow_d;
            v_upper_plus_q  <= v_upper_plus_d;
            v_upper_minus_q <= v_upper_minus_d;
            q_value_q       <= q_value_d;
            q_valid_q       <= q_valid_d;
            iter_cnt_q      <= iter_cnt_d;
            fix_idx_q       <= fix_idx_d;
            ext_rd_valid_q  <= ext_rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clear_n && hist_wr_en) begin
            q_hist_q[iter_cnt_q] <= q_value_d;
        end
    end

    dual_port_v_ram_div #(
        .DIGITS     (DIGITS),
        .NUM_SLICES (NUM_SLICES),
        .AW         (SLICE_AW)
    ) u_ram (
        .clk         (clk),
        .wr_en       (ram_wr_en && clear_n),
        .wr_addr     (slice_q),
        .wr_data     ({sum_p[DIGITS-1:0], sum_m[DIGITS-1:0]}),
        .borrow_rd   (borrow_rd),
        .borrow_addr (bcnt_q[SLICE_AW-1:0]),
        .ext_rd_en   (ext_rd_en),
        .ext_rd_addr (v_rd_addr),
        .rd_data     (rd_data)
    );

    // Outputs are forced low while clear_n is held, even before the first edge.
    assign ext_out_en    = clear_n && ext_rd_valid_q && (state_q == ST_IDLE);
    assign v_plus_rd     = ext_out_en ? rd_vp : '0;
    assign v_minus_rd    = ext_out_en ? rd_vm : '0;
    assign in_ready      = clear_n && (state_q == ST_ADD);
    assign busy          = clear_n && (state_q != ST_IDLE);
    assign q_valid       = clear_n && q_valid_q;
    assign q_value       = clear_n ? q_value_q : Q_ZERO;
    assign iter_cnt      = clear_n ? iter_cnt_q : '0;
    assign v_upper_plus  = clear_n ? v_upper_plus_q : '0;
    assign v_upper_minus = clear_n ? v_upper_minus_q : '0;

endmodule

// File: tb/tb_v_value_slice_engine.sv
// Directed, table-driven bench for v_value_slice_engine with two slices per
// iteration, plus hand sequences for reset abort, replay, stall and wrap.
module tb_v_value_slice_engine;

    localparam int DIGITS     = 4;
    localparam int N          = 2;
    localparam int UPPER_BITS = 6;
    localparam int Q_DEPTH    = 16;
    localparam int SLICE_AW   = 1;
    localparam int Q_AW       = 4;

    logic                  clk = 1'b0;
    logic                  clear_n;
    logic                  start;
    logic                  fixing;
    logic [Q_AW-1:0]       fix_idx;
    logic                  in_valid;
    logic                  in_ready;
    logic [DIGITS-1:0]     q_plus_vec, q_minus_vec, residue_plus, residue_minus;
    logic [UPPER_BITS-1:0] res_upper_plus, res_upper_minus;
    logic [1:0]            x_value_reg;
    logic                  v_rd_en;
    logic [SLICE_AW-1:0]   v_rd_addr;
    logic [DIGITS-1:0]     v_plus_rd, v_minus_rd;
    logic [UPPER_BITS-1:0] v_upper_plus, v_upper_minus;
    logic                  busy;
    logic                  q_valid;
    logic [1:0]            q_value;
    logic [Q_AW-1:0]       iter_cnt;

    typedef struct {
        logic [3:0] qp0, qp1, qm0, qm1, rp0, rp1, rm0, rm1;
        logic [5:0] up, um;
        logic [1:0] x;
        logic [3:0] evp0, evp1, evm0, evm1;
        logic [5:0] eup, eum;
        logic [1:0] eq;
    } vec_t;

    vec_t vecs [12];
    vec_t last_vec;
    logic [1:0] exp_hist [Q_DEPTH];
    int exp_iter = 0;
    int n_compared = 0;
    int n_mismatched = 0;
    int edge_cnt = 0;

    v_value_slice_engine #(
        .DIGITS     (DIGITS),
        .NUM_SLICES (N),
        .UPPER_BITS (UPPER_BITS),
        .Q_DEPTH    (Q_DEPTH)
    ) dut (
        .clk             (clk),
        .clear_n         (clear_n),
        .start           (start),
        .fixing          (fixing),
        .fix_idx         (fix_idx),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .q_plus_vec      (q_plus_vec),
        .q_minus_vec     (q_minus_vec),
        .residue_plus    (residue_plus),
        .residue_minus   (residue_minus),
        .res_upper_plus  (res_upper_plus),
        .res_upper_minus (res_upper_minus),
        .x_value_reg     (x_value_reg),
        .v_rd_en         (v_rd_en),
        .v_rd_addr       (v_rd_addr),
        .v_plus_rd       (v_plus_rd),
        .v_minus_rd      (v_minus_rd),
        .v_upper_plus    (v_upper_plus),
        .v_upper_minus   (v_upper_minus),
        .busy            (busy),
        .q_valid         (q_valid),
        .q_value         (q_value),
        .iter_cnt        (iter_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Waits for the q_valid pulse and reports edges counted from the accept edge.
    task automatic waitQValid(input string tag, input int start_edge, output int lat);
        bit got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk); #1;
            if (q_valid) got = 1'b1;
        end
        checkOutput({tag, "_qvalid_seen"}, 32'(got), 32'd1);
        lat = edge_cnt - start_edge;
    endtask

    task automatic readRam(input string tag, input vec_t v);
        for (int s = 0; s < N; s++) begin
            @(negedge clk);
            v_rd_en   = 1'b1;
            v_rd_addr = SLICE_AW'(s);
            @(posedge clk); #1;
            checkOutput($sformatf("%s_ram_vp%0d", tag, s), 32'(v_plus_rd),  32'((s == 0) ? v.evp0 : v.evp1));
            checkOutput($sformatf("%s_ram_vm%0d", tag, s), 32'(v_minus_rd), 32'((s == 0) ? v.evm0 : v.evm1));
        end
        @(negedge clk);
        v_rd_addr = 1'b1;
    endtask

    // One full iteration; glitch holds start/fixing high while busy, which must be ignored.
    task automatic applyStimulus(input vec_t v, input string tag, input int stall_at,
                                 input int stall_len, input bit glitch);
        int start_edge;
        int lat;
        res_upper_plus  = v.up;
        res_upper_minus = v.um;
        x_value_reg     = v.x;
        @(negedge clk);
        start  = 1'b1;
        fixing = 1'b0;
        @(posedge clk); #1;
        start_edge = edge_cnt;
        for (int s = 0; s < N; s++) begin
            if (s == stall_at) begin
                for (int k = 0; k < stall_len; k++) begin
                    @(negedge clk);
                    start = glitch; fixing = glitch; fix_idx = 4'h0; in_valid = 1'b0;
                    q_plus_vec = 4'hF; residue_plus = 4'hF;
                    checkOutput($sformatf("%s_stall%0d_in_ready", tag, k), 32'(in_ready), 32'd1);
                    @(posedge clk); #1;
                end
            end
            @(negedge clk);
            start = glitch; fixing = glitch; fix_idx = 4'h0; in_valid = 1'b1;
            q_plus_vec    = (s == 0) ? v.qp0 : v.qp1;
            q_minus_vec   = (s == 0) ? v.qm0 : v.qm1;
            residue_plus  = (s == 0) ? v.rp0 : v.rp1;
            residue_minus = (s == 0) ? v.rm0 : v.rm1;
            checkOutput($sformatf("%s_beat%0d_in_ready", tag, s), 32'(in_ready), 32'd1);
            checkOutput($sformatf("%s_beat%0d_busy_rd", tag, s), 32'(v_plus_rd), 32'd0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        in_valid = 1'b0; start = 1'b0; fixing = 1'b0;
        q_plus_vec = '0; q_minus_vec = '0; residue_plus = '0; residue_minus = '0;
        checkOutput({tag, "_upper_in_ready"}, 32'(in_ready), 32'd0);
        waitQValid(tag, start_edge, lat);
        exp_hist[exp_iter] = v.eq;
        exp_iter = (exp_iter + 1) % Q_DEPTH;
        last_vec = v;
        checkOutput({tag, "_latency"}, 32'(lat), 32'(2 * N + 3 + stall_len));
        checkOutput({tag, "_q_value"}, 32'(q_value), 32'(v.eq));
        checkOutput({tag, "_v_upper_plus"}, 32'(v_upper_plus), 32'(v.eup));
        checkOutput({tag, "_v_upper_minus"}, 32'(v_upper_minus), 32'(v.eum));
        checkOutput({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(exp_iter));
        @(posedge clk); #1;
        checkOutput({tag, "_qvalid_pulse"}, 32'(q_valid), 32'd0);
        readRam(tag, v);
    endtask

    // Replay: q_valid lands in the cycle after FIX, one edge after the accept edge.
    task automatic runFix(input int idx, input string tag);
        int start_edge;
        int lat;
        @(negedge clk);
        start = 1'b1; fixing = 1'b1; fix_idx = Q_AW'(idx);
        @(posedge clk); #1;
        start_edge = edge_cnt;
        @(negedge clk);
        start = 1'b0; fixing = 1'b0; fix_idx = 4'hF;
        waitQValid(tag, start_edge - 1, lat);
        checkOutput({tag, "_latency"}, 32'(lat), 32'd2);
        checkOutput({tag, "_q_value"}, 32'(q_value), 32'(exp_hist[idx]));
        checkOutput({tag, "_iter_cnt"}, 32'(iter_cnt), 32'(exp_iter));
        checkOutput({tag, "_v_upper_plus"}, 32'(v_upper_plus), 32'(last_vec.eup));
        checkOutput({tag, "_v_upper_minus"}, 32'(v_upper_minus), 32'(last_vec.eum));
        readRam(tag, last_vec);
    endtask

    initial begin
        int seen;
        //           qp0   qp1   qm0   qm1   rp0   rp1   rm0   rm1   up     um     x      evp0  evp1  evm0  evm1  eup    eum    eq
        vecs[0]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h0, 4'h0, 6'h10, 6'h00, 2'b00, 4'h1, 4'h2, 4'h0, 4'h0, 6'h10, 6'h00, 2'b10};
        vecs[1]  = '{4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 4'h0, 6'h00, 6'h00, 2'b00, 4'h0, 4'h1, 4'h0, 4'h0, 6'h00, 6'h00, 2'b00};
        vecs[2]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 6'h00, 6'h00, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0, 6'h00, 6'h00, 2'b00};
        vecs[3]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6'h07, 6'h00, 2'b10, 4'h0, 4'h0, 4'h0, 4'h0, 6'h08, 6'h00, 2'b10};
        vecs[4]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 6'h00, 6'h08, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0, 6'h00, 6'h08, 2'b01};
        vecs[5]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6'h00, 6'h07, 2'b01, 4'h0, 4'h0, 4'h0, 4'h0, 6'h00, 6'h08, 2'b01};
        vecs[6]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6'h1F, 6'h00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 6'h1F, 6'h00, 2'b10};
        vecs[7]  = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 6'h20, 6'h00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 6'h20, 6'h00, 2'b01};
        vecs[8]  = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h0, 6'h3F, 6'h00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h0, 6'h00, 6'h00, 2'b00};
        vecs[9]  = '{4'h0, 4'h0, 4'h8, 4'hF, 4'h0, 4'h0, 4'h8, 4'h1, 6'h10, 6'h00, 2'b00, 4'h0, 4'h0, 4'h0, 4'h1, 6'h10, 6'h01, 2'b10};
        vecs[10] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h1, 4'h0, 6'h04, 6'h00, 2'b00, 4'h0, 4'h1, 4'h1, 4'h0, 6'h04, 6'h00, 2'b10};
        vecs[11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 6'h04, 6'h00, 2'b00, 4'h0, 4'h0, 4'h1, 4'h0, 6'h04, 6'h00, 2'b00};

        clear_n = 1'b0; start = 1'b0; fixing = 1'b0; fix_idx = '0; in_valid = 1'b0;
        q_plus_vec = '0; q_minus_vec = '0; residue_plus = '0; residue_minus = '0;
        res_upper_plus = '0; res_upper_minus = '0; x_value_reg = '0;
        v_rd_en = 1'b1; v_rd_addr = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("por_busy", 32'(busy), 32'd0);
        checkOutput("por_in_ready", 32'(in_ready), 32'd0);
        checkOutput("por_q_valid", 32'(q_valid), 32'd0);
        checkOutput("por_q_value", 32'(q_value), 32'd0);
        checkOutput("por_iter_cnt", 32'(iter_cnt), 32'd0);
        checkOutput("por_v_upper_plus", 32'(v_upper_plus), 32'd0);
        checkOutput("por_v_plus_rd", 32'(v_plus_rd), 32'd0);
        @(negedge clk);
        clear_n = 1'b1;

        // Reset held for two cycles in the middle of the borrow pass.
        res_upper_plus = 6'h10;
        @(negedge clk); start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; residue_plus = 4'h1;
        @(posedge clk); #1;
        @(negedge clk); residue_plus = 4'h2;
        @(posedge clk); #1;
        @(negedge clk); in_valid = 1'b0; residue_plus = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        @(negedge clk); clear_n = 1'b0; #1;
        checkOutput("rst_held_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_q_valid", 32'(q_valid), 32'd0);
        checkOutput("rst_q_value", 32'(q_value), 32'd0);
        checkOutput("rst_iter_cnt", 32'(iter_cnt), 32'd0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_v_upper_plus", 32'(v_upper_plus), 32'd0);
        @(negedge clk); clear_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (q_valid || busy) seen++;
        end
        checkOutput("rst_no_resume", 32'(seen), 32'd0);
        checkOutput("rst_iter_after", 32'(iter_cnt), 32'd0);

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i], $sformatf("vec%0d", i), -1, 0, (i == 6));
        end

        runFix(3, "fix3");
        runFix(4, "fix4");

        applyStimulus(vecs[0], "stall", 1, 3, 1'b0);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(vecs[1], $sformatf("fill%0d", i), -1, 0, 1'b0);
        end
        applyStimulus(vecs[4], "wrap", -1, 0, 1'b0);
        checkOutput("wrap_iter_cnt_one", 32'(iter_cnt), 32'd1);
        runFix(0, "fix0_overwritten");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
